// File: rtl/fm_rescale.sv
// Row buffer that scales every lane of each buffered vector by a per-row fixed-point factor.
// Latency: first y_valid 2 cycles after DRAIN entry, then one vector per cycle.
// Backpressure: !y_ready freezes the read pipeline; x_ready is low while waiting for scale or draining.
module fm_rescale #(
  parameter int bitwidth = 16,
  parameter int N        = 8,
  parameter int FRAC     = 8,
  parameter int DEPTH    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N*bitwidth-1:0] x,
  input  logic                  x_valid,
  input  logic                  x_last,
  output logic                  x_ready,
  input  logic [bitwidth-1:0]   scale,
  input  logic                  scale_valid,
  output logic [N*bitwidth-1:0] y,
  output logic                  y_valid,
  output logic                  y_last,
  input  logic                  y_ready,
  output logic                  busy,
  output logic                  overflow
);
  localparam int BW = bitwidth;
  localparam int VW = N * BW;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic signed [2*BW-1:0] MAXV = {{(BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [2*BW-1:0] MINV = ~MAXV;
  localparam logic signed [2*BW-1:0] RND  = {{(2*BW-1){1'b0}}, 1'b1} << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SCALE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [BW-1:0]   scale_q, scale_d;
  logic            pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            rdy_en_q;

  logic [VW-1:0]   mem_q [DEPTH];
  logic [VW-1:0]   s1_dat_q;
  logic            s1_vld_q, s1_last_q;
  logic [VW-1:0]   y_q;
  logic            y_vld_q, y_last_q;
  logic [VW-1:0]   y_calc;

  logic x_acc, at_cap, row_end, scale_take, adv, issue, done;

  assign x_acc      = x_valid && x_ready;
  assign at_cap     = (wr_cnt_q == CW'(DEPTH - 1));
  assign row_end    = x_acc && (x_last || at_cap);
  assign scale_take = scale_valid && ((state_q == FILL) || (state_q == WAIT_SCALE));
  // The output register and the read stage advance together whenever the output slot can move.
  assign adv        = !y_vld_q || y_ready;
  assign issue      = (state_q == DRAIN) && (rd_cnt_q < len_q) && adv;
  assign done       = y_vld_q && y_ready && y_last_q;

  // State and control registers; everything buffered is forgotten on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      scale_q  <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      scale_q  <= scale_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next state: a row ends on x_last or on the DEPTH-th vector; drain only once a scale is known.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: begin
        if (row_end)    state_d = (pend_q || scale_take) ? DRAIN : WAIT_SCALE;
        else if (x_acc) state_d = FILL;
      end
      WAIT_SCALE: if (scale_valid) state_d = DRAIN;
      DRAIN:      if (done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; x_ready stays low until the first edge out of reset.
  always_comb begin
    x_ready = rdy_en_q && ((state_q == IDLE) || (state_q == FILL));
    busy    = (state_q != IDLE);
  end

  // Counter, scale and overflow bookkeeping.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    scale_d  = scale_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    if (x_acc) wr_cnt_d = wr_cnt_q + CW'(1);
    if (row_end) len_d = wr_cnt_q + CW'(1);
    if (x_acc && at_cap && !x_last) ovf_d = 1'b1;
    if (scale_take) begin
      scale_d = scale;
      pend_d  = 1'b1;
    end
    if (issue) rd_cnt_d = rd_cnt_q + CW'(1);
    if (done) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      pend_d   = 1'b0;
    end
  end

  // Row storage and the registered read port feeding the arithmetic stage.
  always_ff @(posedge clk) begin
    if (x_acc) mem_q[wr_cnt_q[AW-1:0]] <= x;
    if (issue) s1_dat_q <= mem_q[rd_cnt_q[AW-1:0]];
  end

  // Per lane: signed product, add half an LSB, arithmetic shift, clamp to the lane range.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [2*BW-1:0] prod, rnd;
    assign prod = $signed(s1_dat_q[i*BW +: BW]) * $signed(scale_q);
    assign rnd  = (prod + RND) >>> FRAC;
    assign y_calc[i*BW +: BW] = (rnd > MAXV) ? MAXV[BW-1:0] :
                                (rnd < MINV) ? MINV[BW-1:0] : rnd[BW-1:0];
  end

  // Read-valid stage and output register; both hold while the output is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      y_q       <= '0;
      y_vld_q   <= 1'b0;
      y_last_q  <= 1'b0;
    end else if (adv) begin
      s1_vld_q  <= issue;
      s1_last_q <= (rd_cnt_q + CW'(1)) == len_q;
      y_vld_q   <= s1_vld_q;
      y_last_q  <= s1_vld_q && s1_last_q;
      if (s1_vld_q) y_q <= y_calc;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_vld_q;
  assign y_last   = y_last_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fm_rescale.sv
// Self-checking bench for fm_rescale: directed tables, timing corners and randomized rows
// against an arithmetic reference model with an output scoreboard.
module tb_fm_rescale;
  localparam int BW = 16;
  localparam int N = 4;
  localparam int FRAC = 8;
  localparam int DEPTH = 8;
  localparam int VW = N * BW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [VW-1:0] x = '0;
  logic x_valid = 1'b0, x_last = 1'b0, x_ready;
  logic [BW-1:0] scale = '0;
  logic scale_valid = 1'b0;
  logic [VW-1:0] y;
  logic y_valid, y_last, y_ready, busy, overflow;

  int rdy_mode = 1;         // 0: low, 1: high, 2: random
  logic rnd_bit = 1'b1;
  assign y_ready = (rdy_mode == 2) ? rnd_bit : (rdy_mode == 1);

  fm_rescale #(.bitwidth(BW), .N(N), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .x_last(x_last), .x_ready(x_ready),
    .scale(scale), .scale_valid(scale_valid), .y(y), .y_valid(y_valid), .y_last(y_last),
    .y_ready(y_ready), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  typedef logic [VW:0] ovec_t;  // {last, data}
  ovec_t got_q[$];
  ovec_t exp_q[$];
  logic [VW-1:0] sent_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int stall_chk = 0;
  int stab_err = 0;
  logic prev_stall = 1'b0;
  logic [VW+1:0] prev_snap = '0;

  // Transfer collector and stall-stability watcher.
  always @(negedge clk) begin
    if (rstn && prev_stall) begin
      stall_chk <= stall_chk + 1;
      if ({y, y_valid, y_last} !== prev_snap) stab_err <= stab_err + 1;
    end
    prev_stall <= rstn && y_valid && !y_ready;
    prev_snap  <= {y, y_valid, y_last};
    if (rstn && y_valid && y_ready) got_q.push_back({y_last, y});
  end

  typedef struct {
    logic [BW-1:0] xv;
    logic [BW-1:0] sv;
    logic [BW-1:0] ev;
  } vec_t;
  vec_t tbl[9];

  task automatic checki(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic checkv(input string nm, input ovec_t got, input ovec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: exact rational product, rounded half up, clamped to the lane range.
  function automatic logic [BW-1:0] ref_lane(input logic [BW-1:0] xv, input logic [BW-1:0] sv);
    longint p, q;
    p = longint'($signed(xv)) * longint'($signed(sv)) + (longint'(1) << (FRAC - 1));
    if (p >= 0) q = p / (longint'(1) << FRAC);
    else        q = -((-p + (longint'(1) << FRAC) - 1) / (longint'(1) << FRAC));
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[BW-1:0];
  endfunction

  function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] v, input logic [BW-1:0] sv);
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = ref_lane(v[i*BW +: BW], sv);
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) begin
      logic [31:0] r;
      r = $urandom;
      v[i*BW +: BW] = (r[1:0] == 2'd0) ? r[31:16] : {{5{r[12]}}, r[12:2]};
    end
    return v;
  endfunction

  task automatic send_vecs(input int len, input bit with_last, input int scale_at,
                           input logic [BW-1:0] sc, input bit fixed, input logic [BW-1:0] fixv);
    for (int i = 0; i < len; i++) begin
      logic [VW-1:0] v;
      int t;
      v = fixed ? {N{fixv}} : rand_vec();
      sent_q.push_back(v);
      x = v;
      x_valid = 1'b1;
      x_last = with_last && (i == len - 1);
      scale_valid = (i == scale_at);
      scale = sc;
      t = 0;
      @(negedge clk);
      while (!x_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (!x_ready) checki("x_accept_timeout", 0, 1);
      step();
      x_valid = 1'b0;
      x_last = 1'b0;
      scale_valid = 1'b0;
    end
  endtask

  task automatic pulse_scale(input logic [BW-1:0] sc);
    scale = sc;
    scale_valid = 1'b1;
    step();
    scale_valid = 1'b0;
  endtask

  task automatic push_exp(input int cnt, input logic [BW-1:0] sc);
    for (int i = 0; i < cnt; i++) begin
      logic [VW-1:0] v;
      v = sent_q.pop_front();
      exp_q.push_back({(i == cnt - 1), ref_vec(v, sc)});
    end
  endtask

  task automatic wait_outputs();
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_all(input string nm);
    while (exp_q.size() > 0) begin
      ovec_t e;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_missing got=none expected=%h", nm, e);
      end else begin
        checkv(nm, got_q.pop_front(), e);
      end
    end
    checki({nm, "_extra"}, got_q.size(), 0);
    got_q.delete();
    step();
  endtask

  // Counts negedges after the current point until y_valid is seen (20 = never).
  task automatic first_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!y_valid && k < 20);
  endtask

  initial begin
    int k;
    int seen;
    int pat[8];
    tbl[0] = '{16'h7000, 16'h0200, 16'h7FFF};
    tbl[1] = '{16'h9000, 16'h0200, 16'h8000};
    tbl[2] = '{16'h0001, 16'h0080, 16'h0001};
    tbl[3] = '{16'h0100, 16'h0200, 16'h0200};
    tbl[4] = '{16'hFF00, 16'h0180, 16'hFE80};
    tbl[5] = '{16'hFFFF, 16'h0080, 16'h0000};
    tbl[6] = '{16'h0003, 16'h0080, 16'h0002};
    tbl[7] = '{16'hFFFD, 16'h0080, 16'hFFFF};
    tbl[8] = '{16'h8000, 16'h8000, 16'h7FFF};
    pat = '{1, 0, 0, 1, 1, 1, 1, 1};

    // Reset values
    repeat (3) @(negedge clk);
    checki("rst_y_valid", y_valid, 0);
    checki("rst_y_last", y_last, 0);
    checkv("rst_y", {1'b0, y}, '0);
    checki("rst_busy", busy, 0);
    checki("rst_overflow", overflow, 0);
    checki("rst_x_ready", x_ready, 0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(negedge clk);
    checki("x_ready_before_edge", x_ready, 0);
    step();
    @(negedge clk);
    checki("x_ready_after_reset", x_ready, 1);
    step();

    // 3-vector row, scale arrives later from WAIT_SCALE
    send_vecs(3, 1'b1, -1, '0, 1'b1, 16'h0100);
    step();
    @(negedge clk);
    checki("wait_x_ready", x_ready, 0);
    checki("wait_busy", busy, 1);
    checki("wait_no_y", y_valid, 0);
    step();
    pulse_scale(16'h0200);
    first_valid(k);
    checki("lat_after_scale", k, 3);
    sent_q.delete();
    exp_q.push_back({1'b0, {N{16'h0200}}});
    exp_q.push_back({1'b0, {N{16'h0200}}});
    exp_q.push_back({1'b1, {N{16'h0200}}});
    wait_outputs();
    compare_all("row3");

    // Arithmetic table, each entry a single-vector row
    for (int i = 0; i < 9; i++) begin
      send_vecs(1, 1'b1, -1, '0, 1'b1, tbl[i].xv);
      pulse_scale(tbl[i].sv);
      sent_q.delete();
      exp_q.push_back({1'b1, {N{tbl[i].ev}}});
      wait_outputs();
      compare_all($sformatf("tbl%0d", i));
    end

    // Scale during FILL: straight to DRAIN after x_last
    send_vecs(4, 1'b1, 1, 16'h0180, 1'b0, '0);
    first_valid(k);
    checki("lat_early_scale", k, 3);
    push_exp(4, 16'h0180);
    wait_outputs();
    compare_all("early_row");

    // y_ready pattern 1,0,0,1 while draining
    rdy_mode = 0;
    send_vecs(4, 1'b1, -1, '0, 1'b0, '0);
    pulse_scale(16'h0100);
    first_valid(k);
    checki("stall_first_valid", k, 3);
    for (int p = 0; p < 8; p++) begin
      rdy_mode = pat[p];
      step();
    end
    rdy_mode = 1;
    push_exp(4, 16'h0100);
    wait_outputs();
    compare_all("stall_row");
    checki("stall_observed", int'(stall_chk > 0), 1);
    checki("stall_hold", stab_err, 0);

    // Randomized rows with random downstream readiness
    rdy_mode = 2;
    for (int r = 0; r < 24; r++) begin
      int len, at;
      logic [31:0] rs;
      logic [BW-1:0] sc;
      len = $urandom_range(1, DEPTH);
      at = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : -1;
      rs = $urandom;
      sc = rs[0] ? rs[31:16] : {{6{rs[12]}}, rs[12:3]};
      send_vecs(len, 1'b1, at, sc, 1'b0, '0);
      if (at < 0) pulse_scale(sc);
      push_exp(len, sc);
    end
    wait_outputs();
    compare_all("rand");
    rdy_mode = 1;

    // DEPTH+2 vectors with no x_last
    @(negedge clk);
    checki("ovf_before", overflow, 0);
    step();
    send_vecs(DEPTH + 2, 1'b0, 1, 16'h0100, 1'b0, '0);
    @(negedge clk);
    checki("ovf_set", overflow, 1);
    checki("ovf_newrow_busy", busy, 1);
    checki("ovf_newrow_x_ready", x_ready, 1);
    push_exp(DEPTH, 16'h0100);
    wait_outputs();
    compare_all("ovf_row");
    send_vecs(1, 1'b1, -1, '0, 1'b0, '0);
    pulse_scale(16'h0300);
    push_exp(3, 16'h0300);
    wait_outputs();
    compare_all("after_ovf");
    @(negedge clk);
    checki("ovf_sticky", overflow, 1);
    step();

    // Reset in the middle of DRAIN
    rdy_mode = 0;
    send_vecs(5, 1'b1, 2, 16'h0100, 1'b0, '0);
    first_valid(k);
    checki("mid_drain_valid", k, 3);
    step();
    rstn = 1'b0;
    #1;
    checki("mrst_y_valid", y_valid, 0);
    checki("mrst_busy", busy, 0);
    checki("mrst_x_ready", x_ready, 0);
    checkv("mrst_y", {1'b0, y}, '0);
    checki("mrst_overflow", overflow, 0);
    sent_q.delete();
    rdy_mode = 1;
    repeat (2) step();
    rstn = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (y_valid) seen++;
    end
    checki("no_out_after_rst", seen, 0);
    checki("got_after_rst", got_q.size(), 0);
    step();
    send_vecs(2, 1'b1, -1, '0, 1'b0, '0);
    pulse_scale(16'h0080);
    push_exp(2, 16'h0080);
    wait_outputs();
    compare_all("post_rst");

    checki("stall_hold_final", stab_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_rescale.md
FM_RESCALE -- requirements
Module: fm_rescale

Interface
REQ-001 SHALL have parameter bitwidth, default 16, lane width in bits.
REQ-002 SHALL have parameter N, default 8, lanes per vector.
REQ-003 SHALL have parameter FRAC, default 8, fractional bits of the signed two's-complement fixed-point lane and scale format.
REQ-004 SHALL have parameter DEPTH, default 64, maximum vectors per row held in the row buffer.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port x, input, N*bitwidth: input vector; lane i is x[i*bitwidth +: bitwidth].
REQ-008 SHALL have port x_valid, input, 1: input vector valid.
REQ-009 SHALL have port x_last, input, 1: input vector is the last of its row.
REQ-010 SHALL have port x_ready, output, 1: block accepts an input vector.
REQ-011 SHALL have port scale, input, bitwidth: per-row scale factor.
REQ-012 SHALL have port scale_valid, input, 1: single-cycle strobe qualifying scale.
REQ-013 SHALL have port y, output, N*bitwidth: rescaled vector.
REQ-014 SHALL have port y_valid, output, 1: output vector valid.
REQ-015 SHALL have port y_last, output, 1: output vector is the last of its row.
REQ-016 SHALL have port y_ready, input, 1: downstream accepts the output vector.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port overflow, output, 1: sticky flag, set when a row exceeds DEPTH.

Function
REQ-019 SHALL transfer input on a clk edge with x_valid && x_ready, and output on a clk edge with y_valid && y_ready.
REQ-020 SHALL implement the states IDLE, FILL, WAIT_SCALE and DRAIN.
REQ-021 SHALL drive x_ready=1 in IDLE and FILL, and x_ready=0 in WAIT_SCALE and DRAIN.
REQ-022 SHALL write each accepted vector into the buffer at address wr_cnt, increment wr_cnt, and move from IDLE to FILL on the first accepted vector.
REQ-023 SHALL, on an accepted vector with x_last=1, or on the DEPTH-th accepted vector, record row length L=wr_cnt+1 and leave FILL.
REQ-024 SHALL set overflow when the DEPTH-th accepted vector has x_last=0, treat that vector as the end of the row, and report no error for any further vectors.
REQ-025 SHALL latch scale on scale_valid in FILL or WAIT_SCALE and set scale_pending.
REQ-026 SHALL, at the end of a row, enter DRAIN if scale_pending is set (including a scale_valid in the same cycle) and otherwise enter WAIT_SCALE.
REQ-027 SHALL ignore scale_valid in IDLE and DRAIN.
REQ-028 SHALL move from WAIT_SCALE to DRAIN on the cycle following scale_valid.
REQ-029 SHALL, in DRAIN, read buffer entries 0..L-1 in order and assert y_valid exactly 2 cycles after the DRAIN entry edge.
REQ-030 SHALL sustain 1 vector per cycle while y_ready is held high.
REQ-031 SHALL hold y, y_valid and y_last stable while y_valid && !y_ready.
REQ-032 SHALL compute each lane as y_i = sat(((x_i * scale) + 2^(FRAC-1)) >>> FRAC), using a 2*bitwidth signed product and an arithmetic shift.
REQ-033 SHALL saturate results to the range [-2^(bitwidth-1), 2^(bitwidth-1)-1].
REQ-034 SHALL assert y_last only on output vector L-1.
REQ-035 SHALL, after the y_last transfer, clear wr_cnt and scale_pending and return to IDLE with x_ready=1 on the next cycle.
REQ-036 SHALL ensure that an x_last arriving on the first vector (L=1) yields exactly one output vector with y_last=1.

Reset
REQ-037 SHALL, while rstn=0, put the block in IDLE and drive y_valid=0, y_last=0, y=0, busy=0, overflow=0 and x_ready=0.
REQ-038 SHALL clear wr_cnt, the read counter, scale_pending and the scale register on reset.
REQ-039 SHALL set x_ready=1 on the first clk edge after rstn deasserts.
REQ-040 SHALL, on a reset taken mid-row or mid-drain, discard all buffered data, with no y_valid after reset until a new row and scale arrive.

Verification
REQ-041 SHALL pass: with FRAC=8, a 3-vector row of all lanes 0x0100, x_last on the third vector, then scale=0x0200 -> 3 outputs, all lanes 0x0200, y_last on the third, first y_valid 3 cycles after the scale_valid cycle.
REQ-042 SHALL pass: lanes 0x7000 and 0x9000 with scale=0x0200 -> 0x7FFF and 0x8000; lane 0x0001 with scale=0x0080 -> 0x0001 (round half up).
REQ-043 SHALL pass: scale_valid during FILL, before x_last -> no WAIT_SCALE; DRAIN is entered on the edge after x_last and y_valid asserts 2 cycles later.
REQ-044 SHALL pass: DEPTH+2 vectors with no x_last -> overflow=1; DEPTH outputs with y_last on output DEPTH-1; the remaining 2 vectors start a new row.
REQ-045 SHALL pass: y_ready toggling 1,0,0,1 during DRAIN -> y held stable while stalled, with no vector lost or duplicated.
REQ-046 SHALL pass: rstn pulsed low mid-DRAIN -> y_valid=0 immediately, busy=0, and no outputs until a new row and scale arrive.
